// File: rtl/gpio_irq_pkg.sv
// Shared MCU package: GPIO register offsets and port limits.
// Used by gpio_irq and gpio_sync; edge/IRQ logic is enabled with GPIO_IRQ_EN.
`timescale 1ns/1ps
package gpio_irq_pkg;

  localparam int GPIO_MAX_PORTS = 4;

  localparam logic [2:0] GPIO_OUT    = 3'd0;
  localparam logic [2:0] GPIO_DIR    = 3'd1;
  localparam logic [2:0] GPIO_IN     = 3'd2;
  localparam logic [2:0] GPIO_MASK   = 3'd3;
  localparam logic [2:0] GPIO_STATUS = 3'd4;
  localparam logic [2:0] GPIO_RISE   = 3'd5;
  localparam logic [2:0] GPIO_FALL   = 3'd6;
  localparam logic [2:0] GPIO_TOGGLE = 3'd7;

  localparam logic [1:0] GPIO_PRIME_DONE = 2'd3;

endpackage

// File: rtl/gpio_sync.sv
// 8-bit two-flop pad synchroniser; with GPIO_IRQ_EN it adds a prev stage
// and exports rise/fall vectors for edge detection.
`timescale 1ns/1ps
module gpio_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pin_i,
  output logic [7:0] sync_o
`ifdef GPIO_IRQ_EN
  ,
  output logic [7:0] rise_o,
  output logic [7:0] fall_o
`endif
);

  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_o = sync2_q;

`ifdef GPIO_IRQ_EN
  logic [7:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;
`endif

endmodule

// File: rtl/gpio_irq.sv
// Multi-port GPIO with direction, toggle and optional edge interrupts.
// Define GPIO_IRQ_EN to build MASK/STATUS/RISE/FALL and the irq output.
`timescale 1ns/1ps
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int PORTS = 1,
  parameter int AW    = $clog2(PORTS) + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  input  logic [8*PORTS-1:0]   gpio_i,
  output logic [8*PORTS-1:0]   gpio_o,
  output logic [8*PORTS-1:0]   gpio_oe,
  output logic                 irq
);

  localparam int PW = (AW > 3) ? AW - 3 : 1;

  logic [2:0]    regSel;
  logic [PW-1:0] portIdx;
  logic          portValid;
  logic          wrEn;
  logic          rdEn;
  logic [7:0]    portRd [PORTS];
  logic [7:0]    dout_q;
  logic [7:0]    dout_d;

  assign regSel = addr[2:0];

  generate
    if (AW > 3) begin : g_idx
      assign portIdx = addr[AW-1:3];
    end else begin : g_noidx
      assign portIdx = '0;
    end
  endgenerate

  // Out-of-range port indices are neither written nor read.
  assign portValid = (int'(portIdx) < PORTS);
  assign wrEn      = cs & we & portValid;
  assign rdEn      = cs & ~we & portValid;

`ifdef GPIO_IRQ_EN
  logic [1:0]       prime_q;
  logic [1:0]       prime_d;
  logic             primed;
  logic [PORTS-1:0] portIrq;

  assign primed  = (prime_q == GPIO_PRIME_DONE);
  assign prime_d = primed ? prime_q : prime_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_q <= '0;
    end else begin
      prime_q <= prime_d;
    end
  end

  assign irq = |portIrq;
`else
  assign irq = 1'b0;
`endif

  genvar p;
  generate
    for (p = 0; p < PORTS; p++) begin : g_port
      logic [7:0] out_q;
      logic [7:0] out_d;
      logic [7:0] dir_q;
      logic [7:0] dir_d;
      logic [7:0] inSync;
      logic [7:0] rdVal;
      logic       sel;

      assign sel = wrEn & (portIdx == PW'(p));

`ifdef GPIO_IRQ_EN
      logic [7:0] mask_q;
      logic [7:0] mask_d;
      logic [7:0] status_q;
      logic [7:0] status_d;
      logic [7:0] riseEn_q;
      logic [7:0] riseEn_d;
      logic [7:0] fallEn_q;
      logic [7:0] fallEn_d;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] edgeHit;

      gpio_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (gpio_i[8*p +: 8]),
        .sync_o (inSync),
        .rise_o (rise),
        .fall_o (fall)
      );

      // Clear is applied before the new edges are ORed in so a
      // simultaneous edge always survives a W1C.
      always_comb begin
        mask_d   = mask_q;
        riseEn_d = riseEn_q;
        fallEn_d = fallEn_q;
        status_d = status_q;
        edgeHit  = primed ? ((rise & riseEn_q) | (fall & fallEn_q)) : 8'h00;
        if (sel) begin
          case (regSel)
            GPIO_MASK:   mask_d   = din;
            GPIO_RISE:   riseEn_d = din;
            GPIO_FALL:   fallEn_d = din;
            GPIO_STATUS: status_d = status_q & ~din;
            default:     ;
          endcase
        end
        status_d = status_d | edgeHit;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mask_q   <= '0;
          status_q <= '0;
          riseEn_q <= '0;
          fallEn_q <= '0;
        end else begin
          mask_q   <= mask_d;
          status_q <= status_d;
          riseEn_q <= riseEn_d;
          fallEn_q <= fallEn_d;
        end
      end

      assign portIrq[p] = |(status_q & mask_q);
`else
      gpio_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_i  (gpio_i[8*p +: 8]),
        .sync_o (inSync)
      );
`endif

      always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (sel) begin
          case (regSel)
            GPIO_OUT:    out_d = din;
            GPIO_DIR:    dir_d = din;
            GPIO_TOGGLE: out_d = out_q ^ din;
            default:     ;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= '0;
          dir_q <= '0;
        end else begin
          out_q <= out_d;
          dir_q <= dir_d;
        end
      end

      always_comb begin
        rdVal = 8'h00;
        case (regSel)
          GPIO_OUT:    rdVal = out_q;
          GPIO_DIR:    rdVal = dir_q;
          GPIO_IN:     rdVal = inSync;
`ifdef GPIO_IRQ_EN
          GPIO_MASK:   rdVal = mask_q;
          GPIO_STATUS: rdVal = status_q;
          GPIO_RISE:   rdVal = riseEn_q;
          GPIO_FALL:   rdVal = fallEn_q;
`endif
          default:     rdVal = 8'h00;
        endcase
      end

      assign portRd[p]          = rdVal;
      assign gpio_o[8*p +: 8]   = out_q;
      assign gpio_oe[8*p +: 8]  = dir_q;
    end
  endgenerate

  // Read data is zero whenever no read is in progress, so the top-level
  // data mux can simply OR or select without extra qualification.
  always_comb begin
    dout_d = 8'h00;
    if (rdEn) begin
      for (int i = 0; i < PORTS; i++) begin
        if (portIdx == PW'(i)) begin
          dout_d = portRd[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq with three ports (port index 3 is out of range).
// Interrupt expectations follow GPIO_IRQ_EN so the bench suits either build.
`timescale 1ns/1ps
module tb_gpio_irq;

  localparam int PORTS = 3;
  localparam int AW    = 5;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cs;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic [23:0]   gpio_i;
  logic [23:0]   gpio_o;
  logic [23:0]   gpio_oe;
  logic          irq;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [7:0]  d;
    logic [7:0]  expDout;
    logic [23:0] expOut;
    logic [23:0] expOe;
  } vec_t;

  vec_t vecs[$];

  gpio_irq #(.PORTS(PORTS), .AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: the access lands on the next rising edge.
  task automatic applyStimulus(input logic wr, input logic [4:0] a, input logic [7:0] d);
    cs   = 1'b1;
    we   = wr;
    addr = a;
    din  = d;
    tick();
    cs   = 1'b0;
    we   = 1'b0;
    din  = 8'h00;
  endtask

  function automatic logic [4:0] ra(input int port, input logic [2:0] r);
    return 5'((port << 3) | int'(r));
  endfunction

  function automatic void addVec(input logic wr, input logic [4:0] a, input logic [7:0] d,
                                 input logic [7:0] ed, input logic [23:0] eo, input logic [23:0] eoe);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.expDout = ed; v.expOut = eo; v.expOe = eoe;
    vecs.push_back(v);
  endfunction

  initial begin
    // Register table: each entry is one bus cycle plus the expected state after it.
    addVec(0, ra(0,4), 8'h00, 8'h00,                 24'h000000, 24'h000000);
    addVec(0, ra(0,2), 8'h00, 8'hFF,                 24'h000000, 24'h000000);
    addVec(0, ra(1,2), 8'h00, 8'h80,                 24'h000000, 24'h000000);
    addVec(1, ra(0,1), 8'h0F, 8'h00,                 24'h000000, 24'h00000F);
    addVec(1, ra(0,0), 8'hA5, 8'h00,                 24'h0000A5, 24'h00000F);
    addVec(1, ra(0,7), 8'hFF, 8'h00,                 24'h00005A, 24'h00000F);
    addVec(0, ra(0,0), 8'h00, 8'h5A,                 24'h00005A, 24'h00000F);
    addVec(0, ra(0,7), 8'h00, 8'h00,                 24'h00005A, 24'h00000F);
    addVec(0, ra(0,1), 8'h00, 8'h0F,                 24'h00005A, 24'h00000F);
    addVec(1, ra(0,2), 8'h00, 8'h00,                 24'h00005A, 24'h00000F);
    addVec(0, ra(0,2), 8'h00, 8'hFF,                 24'h00005A, 24'h00000F);
    addVec(1, ra(2,1), 8'hF0, 8'h00,                 24'h00005A, 24'hF0000F);
    addVec(1, ra(2,0), 8'h3C, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(1, ra(3,0), 8'hFF, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(0, ra(3,0), 8'h00, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(0, ra(3,1), 8'h00, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(1, ra(0,3), 8'h01, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(0, ra(0,3), 8'h00, IRQ_ON ? 8'h01 : 8'h00, 24'h3C005A, 24'hF0000F);
    addVec(1, ra(0,5), 8'h01, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(0, ra(0,5), 8'h00, IRQ_ON ? 8'h01 : 8'h00, 24'h3C005A, 24'hF0000F);
    addVec(1, ra(1,6), 8'h80, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(0, ra(1,6), 8'h00, IRQ_ON ? 8'h80 : 8'h00, 24'h3C005A, 24'hF0000F);
    addVec(0, ra(1,4), 8'h00, 8'h00,                 24'h3C005A, 24'hF0000F);
    addVec(1, ra(1,7), 8'h11, 8'h00,                 24'h3C115A, 24'hF0000F);
    addVec(0, ra(1,0), 8'h00, 8'h11,                 24'h3C115A, 24'hF0000F);
    addVec(0, ra(0,6), 8'h00, 8'h00,                 24'h3C115A, 24'hF0000F);

    // Reset with pins already high: nothing may be flagged on release.
    rst    = 1'b1;
    cs     = 1'b0;
    we     = 1'b0;
    addr   = '0;
    din    = 8'h00;
    gpio_i = 24'h0080FF;
    repeat (3) tick();
    checkOutput("reset gpio_o",  gpio_o,  32'h0);
    checkOutput("reset gpio_oe", gpio_oe, 32'h0);
    checkOutput("reset dout",    dout,    32'h0);
    checkOutput("reset irq",     irq,     32'h0);
    rst = 1'b0;
    repeat (10) tick();
    checkOutput("post-reset irq", irq, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].a, vecs[i].d);
      checkOutput($sformatf("vec%0d dout", i),    dout,    32'(vecs[i].expDout));
      checkOutput($sformatf("vec%0d gpio_o", i),  gpio_o,  32'(vecs[i].expOut));
      checkOutput($sformatf("vec%0d gpio_oe", i), gpio_oe, 32'(vecs[i].expOe));
      checkOutput($sformatf("vec%0d irq", i),     irq,     32'h0);
    end

    // Rising edge on port 0 pin 0: IN visible at k+1, flag and irq at k+2.
    gpio_i = 24'h0080FE;
    repeat (4) tick();
    applyStimulus(0, ra(0,4), 8'h00);
    checkOutput("rise pre status", dout, 32'h0);
    gpio_i = 24'h0080FF;
    cs     = 1'b1;
    we     = 1'b0;
    addr   = ra(0,2);
    tick();
    checkOutput("rise IN edge k",   dout, 32'hFE);
    tick();
    checkOutput("rise IN edge k+1", dout, 32'hFE);
    checkOutput("rise irq k+1",     irq,  32'h0);
    tick();
    checkOutput("rise IN edge k+2", dout, 32'hFF);
    checkOutput("rise irq k+2",     irq,  32'(IRQ_ON));
    cs = 1'b0;
    applyStimulus(0, ra(0,4), 8'h00);
    checkOutput("rise status",        dout, IRQ_ON ? 32'h01 : 32'h0);
    applyStimulus(0, ra(0,4), 8'h00);
    checkOutput("status after reread", dout, IRQ_ON ? 32'h01 : 32'h0);
    checkOutput("irq after reread",    irq,  32'(IRQ_ON));

    // W1C landing on the same edge as a new rising edge: the set wins.
    gpio_i = 24'h0080FE;
    repeat (3) tick();
    gpio_i = 24'h0080FF;
    tick();
    tick();
    applyStimulus(1, ra(0,4), 8'h01);
    checkOutput("set-wins irq", irq, 32'(IRQ_ON));
    applyStimulus(0, ra(0,4), 8'h00);
    checkOutput("set-wins status", dout, IRQ_ON ? 32'h01 : 32'h0);
    applyStimulus(1, ra(0,4), 8'h01);
    checkOutput("w1c irq", irq, 32'h0);
    applyStimulus(0, ra(0,4), 8'h00);
    checkOutput("w1c status", dout, 32'h0);

    // Masked falling edge on port 1 pin 7, then unmask and clear.
    gpio_i = 24'h0000FF;
    repeat (3) tick();
    checkOutput("fall masked irq", irq, 32'h0);
    applyStimulus(0, ra(1,4), 8'h00);
    checkOutput("fall status p1", dout, IRQ_ON ? 32'h80 : 32'h0);
    applyStimulus(1, ra(1,3), 8'h80);
    checkOutput("unmask irq", irq, 32'(IRQ_ON));
    applyStimulus(1, ra(1,4), 8'h80);
    checkOutput("fall w1c irq", irq, 32'h0);

    // Asynchronous reset while irq is high and dout holds read data.
    gpio_i = 24'h0000FE;
    repeat (3) tick();
    gpio_i = 24'h0000FF;
    repeat (3) tick();
    checkOutput("pre-reset irq", irq, 32'(IRQ_ON));
    cs   = 1'b1;
    we   = 1'b0;
    addr = ra(0,0);
    tick();
    checkOutput("pre-reset dout", dout, 32'h5A);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst irq",     irq,     32'h0);
    checkOutput("async rst gpio_o",  gpio_o,  32'h0);
    checkOutput("async rst gpio_oe", gpio_oe, 32'h0);
    checkOutput("async rst dout",    dout,    32'h0);
    cs = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    applyStimulus(0, ra(0,4), 8'h00);
    checkOutput("after rst status", dout, 32'h0);
    applyStimulus(0, ra(0,0), 8'h00);
    checkOutput("after rst OUT", dout, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised GPIO peripheral for the 6502 MCU, replacing the single fixed 8-bit output register with PORTS 8-bit ports. Each port has per-pin direction, a synchronised input path, an output toggle register and edge-triggered interrupts, combined onto one level IRQ line to the CPU. It connects to the MCU bus with the same cs/we/addr/din/dout handshake as the UART, and its dout joins the top-level data mux.

## Interface
- PORTS, 1: number of 8-bit ports, 1..4.
- AW, clog2(PORTS)+3: address width. addr = {port index, register[2:0]}.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select from the address decoder.
- we  in  1  CPU write enable.
- addr  in  AW  register address.
- din  in  8  CPU write data.
- dout  out  8  registered read data.
- gpio_i  in  8*PORTS  pad inputs, asynchronous to clk. Port p is on bits [8p+7:8p].
- gpio_o  out  8*PORTS  output register values.
- gpio_oe  out  8*PORTS  output enables, equal to DIR.
- irq  out  1  active-high level interrupt to the CPU IRQ input.

## Operation
Per-port registers, selected by addr[2:0]:
- 0 OUT: read/write.
- 1 DIR: read/write. 1 = output.
- 2 IN: read-only. Synchronised pin state. Writes are ignored.
- 3 MASK: read/write. Interrupt enable per pin.
- 4 STATUS: write-1-to-clear. Read returns pending edge flags.
- 5 RISE: read/write. Enables rising-edge detection per pin.
- 6 FALL: read/write. Enables falling-edge detection per pin.
- 7 TOGGLE: write-only, performs OUT <= OUT ^ din. Reads return 0.

Addressing:
- A port index >= PORTS reads 0 and ignores writes.

Input path, per pin:
- sync1 <= pin, sync2 <= sync1, prev <= sync2.
- rise = sync2 & ~prev; fall = ~sync2 & prev.
- STATUS bit sets when (rise & RISE) | (fall & FALL) and detection is primed.

Priming:
- A 2-bit counter counts up from 0 after reset and saturates at 3.
- Edge detection is suppressed until the counter reaches 3, so pins already high at reset release set no flags.

Interrupt and register rules:
- irq = OR over all ports of (STATUS & MASK). irq is combinational from registers and has no extra delay.
- If an edge and a W1C on the same bit land in the same cycle, the set wins.
- A read never clears STATUS.
- Writing MASK does not alter STATUS. A masked pending flag raises irq as soon as it is unmasked.
- A write to TOGGLE while DIR = 0 still changes OUT; gpio_oe gates the pad.

## Timing
Reset:
- Every register, sync flop, prev flop and the prime counter clear to 0.
- gpio_o = 0, gpio_oe = 0, dout = 0, irq = 0 during and after reset.
- Reset asserted mid-operation discards all pending flags immediately.

Bus:
- A write takes effect on the clk edge where cs & we = 1.
- A read has 1-cycle latency. On each edge, dout <= selected register when cs & ~we, else dout <= 0. This matches the registered mux select at the top level.
- Bus accesses have no wait states and no back-pressure.

Input latency:
- A pin change sampled at edge k appears in sync2 and IN at edge k+1.
- The matching STATUS bit sets at edge k+2.
- irq rises immediately after edge k+2.
- Glitches shorter than one clk period may be missed; this is acceptable.

## Configuration
- GPIO_IRQ_EN defined: full edge and interrupt logic as above.
- GPIO_IRQ_EN undefined:
  - Registers 3–6 read 0 and ignore writes.
  - The prev flops, prime counter and STATUS storage are removed.
  - irq is tied to 0.
  - OUT, DIR, IN and TOGGLE behave identically in both builds.

## Structure
- The shared MCU package holds the register offset constants (GPIO_OUT … GPIO_TOGGLE = 0..7) and the maximum port count.
- One sub-module, gpio_sync: an 8-bit two-flop synchroniser plus prev stage, with async reset. It outputs sync and the rise/fall vectors. It is instantiated once per port.

## Test plan
- Reset with gpio_i = 8'hFF: after release and 10 cycles, STATUS reads 8'h00, irq = 0, and IN reads 8'hFF.
- Write DIR = 8'h0F, OUT = 8'hA5, then TOGGLE = 8'hFF: gpio_o = 8'h5A and gpio_oe = 8'h0F. OUT reads 8'h5A one cycle after the read address.
- Set RISE = 8'h01 and MASK = 8'h01, then drive pin 0 from 0 to 1 at edge k: IN bit 0 = 1 from edge k+1, STATUS = 8'h01 and irq = 1 after edge k+2.
- Pending STATUS = 8'h01 with a W1C of 8'h01 issued in the same cycle as a new rising edge on pin 0: STATUS stays 8'h01 and irq stays 1.
- PORTS = 2: a falling edge on port 1 pin 7 with FALL = 8'h80 and MASK = 0 sets STATUS(port 1) = 8'h80 with irq = 0. Writing MASK = 8'h80 raises irq. W1C of 8'h80 drops irq the next cycle.
- Reset asserted while irq = 1: irq, gpio_o and dout go to 0 asynchronously, without waiting for a clk edge.
